// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: 2-flop synchronizer, shared sample tick, per-bit
// stability counter, and registered rise/fall/change pulses.
module switch_debouncer #(
   parameter int NUM_SW       = 18,
   parameter int TICK_DIV     = 50000,
   parameter int STABLE_TICKS = 10
) (
   input  logic              CLOCK_50_I,
   input  logic              RESET_I,
   input  logic [NUM_SW-1:0] SWITCH_I,
   output logic [NUM_SW-1:0] SWITCH_DB_O,
   output logic [NUM_SW-1:0] SWITCH_RISE_O,
   output logic [NUM_SW-1:0] SWITCH_FALL_O,
   output logic              CHANGE_O,
   output logic              TICK_O
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = $clog2(STABLE_TICKS) + 1;

   logic [NUM_SW-1:0] sync_a;
   logic [NUM_SW-1:0] sync_b;
   logic [TW-1:0]     tick_cnt;
   logic              tick;
   logic [CW-1:0]     cnt [NUM_SW];
   logic [NUM_SW-1:0] accept;

   assign tick   = (tick_cnt == TW'(TICK_DIV - 1));
   assign TICK_O = tick;

   // A bit is accepted on the tick that would take its counter past STABLE_TICKS-1.
   always_comb begin
      accept = '0;
      for (int unsigned i = 0; i < NUM_SW; i++) begin
         accept[i] = tick && (sync_b[i] != SWITCH_DB_O[i]) &&
                     (cnt[i] == CW'(STABLE_TICKS - 1));
      end
   end

   always_ff @(posedge CLOCK_50_I) begin
      if (RESET_I) begin
         sync_a        <= '0;
         sync_b        <= '0;
         tick_cnt      <= '0;
         SWITCH_DB_O   <= '0;
         SWITCH_RISE_O <= '0;
         SWITCH_FALL_O <= '0;
         CHANGE_O      <= 1'b0;
         for (int unsigned i = 0; i < NUM_SW; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync_a        <= SWITCH_I;
         sync_b        <= sync_a;
         tick_cnt      <= tick ? '0 : tick_cnt + TW'(1);
         SWITCH_DB_O   <= (SWITCH_DB_O & ~accept) | (sync_b & accept);
         SWITCH_RISE_O <= accept & sync_b;
         SWITCH_FALL_O <= accept & ~sync_b;
         CHANGE_O      <= |accept;
         for (int unsigned i = 0; i < NUM_SW; i++) begin
            if ((sync_b[i] == SWITCH_DB_O[i]) || accept[i]) begin
               cnt[i] <= '0;
            end else if (tick) begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed self-checking bench for switch_debouncer with TICK_DIV=4, STABLE_TICKS=3.
module tb_switch_debouncer;

   logic        clk;
   logic        rst;
   logic [17:0] sw;
   logic [17:0] db;
   logic [17:0] rise;
   logic [17:0] fall;
   logic        change;
   logic        tick;

   int n_cmp;
   int n_err;

   int          hit;
   logic [17:0] rise_hit;
   logic [17:0] fall_hit;
   logic        chg_hit;
   int          rise_cyc;
   int          fall_cyc;
   int          chg_cyc;
   int          pulses;

   switch_debouncer #(
      .NUM_SW      (18),
      .TICK_DIV    (4),
      .STABLE_TICKS(3)
   ) dut (
      .CLOCK_50_I   (clk),
      .RESET_I      (rst),
      .SWITCH_I     (sw),
      .SWITCH_DB_O  (db),
      .SWITCH_RISE_O(rise),
      .SWITCH_FALL_O(fall),
      .CHANGE_O     (change),
      .TICK_O       (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Steps n cycles; records the first cycle where (db & mask) == target and pulse counts.
   task automatic observe(input int n, input logic [17:0] mask, input logic [17:0] target,
                          input bit chk_tick);
      hit = 0; rise_hit = '0; fall_hit = '0; chg_hit = 1'b0;
      rise_cyc = 0; fall_cyc = 0; chg_cyc = 0;
      for (int m = 1; m <= n; m++) begin
         step();
         if (chk_tick) check("tick_phase", 64'(tick), 64'((m % 4) == 3));
         if (rise != '0) rise_cyc++;
         if (fall != '0) fall_cyc++;
         if (change) chg_cyc++;
         if (hit == 0 && (db & mask) == target) begin
            hit = m; rise_hit = rise; fall_hit = fall; chg_hit = change;
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      sw  = 18'h3FFFF;

      // Reset held 5 cycles with all switches high
      for (int i = 0; i < 5; i++) begin
         step();
         check("reset_outputs", {db, rise, fall, change, tick}, '0);
      end
      rst = 1'b0;
      observe(20, 18'h3FFFF, 18'h3FFFF, 1'b1);
      check("held_window", 64'(hit >= 11 && hit <= 14), 1);
      check("held_rise_vec", rise_hit, 18'h3FFFF);
      check("held_change", chg_hit, 1);
      check("held_rise_cnt", rise_cyc, 1);
      check("held_fall_cnt", fall_cyc, 0);

      sw  = '0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      check("reclear_db", db, 18'h0);

      // Clean rise on bit 0
      sw[0] = 1'b1;
      observe(20, 18'h00001, 18'h00001, 1'b0);
      check("b0_window", 64'(hit >= 11 && hit <= 14), 1);
      check("b0_rise_vec", rise_hit, 18'h00001);
      check("b0_change", chg_hit, 1);
      check("b0_rise_cnt", rise_cyc, 1);
      check("b0_fall_cnt", fall_cyc, 0);
      check("b0_db", db, 18'h00001);

      // Bit 1 bouncing every 3 cycles, then held high
      pulses = 0;
      for (int t = 0; t < 40; t++) begin
         if ((t % 3) == 0) sw[1] = ~sw[1];
         step();
         if (rise != '0 || fall != '0 || change) pulses++;
      end
      check("b1_bounce_pulses", pulses, 0);
      check("b1_bounce_db", db, 18'h00001);
      sw[1] = 1'b1;
      observe(20, 18'h00002, 18'h00002, 1'b0);
      check("b1_window", 64'(hit >= 11 && hit <= 14), 1);
      check("b1_rise_vec", rise_hit, 18'h00002);
      check("b1_rise_cnt", rise_cyc, 1);

      // Bits 17:16 rise together
      sw[17:16] = 2'b11;
      observe(20, 18'h30000, 18'h30000, 1'b0);
      check("b1716_window", 64'(hit >= 11 && hit <= 14), 1);
      check("b1716_rise_vec", rise_hit, 18'h30000);
      check("b1716_change", chg_hit, 1);
      check("b1716_rise_cnt", rise_cyc, 1);
      check("b1716_chg_cnt", chg_cyc, 1);

      // Bit 2 up, then down
      sw[2] = 1'b1;
      observe(20, 18'h00004, 18'h00004, 1'b0);
      check("b2_up_window", 64'(hit >= 11 && hit <= 14), 1);
      sw[2] = 1'b0;
      observe(20, 18'h00004, 18'h00000, 1'b0);
      check("b2_dn_window", 64'(hit >= 11 && hit <= 14), 1);
      check("b2_fall_vec", fall_hit, 18'h00004);
      check("b2_fall_cnt", fall_cyc, 1);
      check("b2_rise_cnt", rise_cyc, 0);
      check("b2_db", db, 18'h30003);

      // Bit 3 up, reset pulse mid-debounce
      sw[3] = 1'b1;
      pulses = 0;
      for (int t = 0; t < 6; t++) begin
         step();
         if (rise != '0 || fall != '0 || change) pulses++;
      end
      check("b3_pre_pulses", pulses, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("b3_reset_outputs", {db, rise, fall, change}, '0);
      observe(20, 18'h00008, 18'h00008, 1'b0);
      check("b3_window", 64'(hit >= 11 && hit <= 14), 1);
      check("b3_rise_vec", rise_hit, 18'h3000B);
      check("b3_rise_cnt", rise_cyc, 1);
      check("b3_fall_cnt", fall_cyc, 0);
      check("b3_db", db, 18'h3000B);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 SHALL have parameter NUM_SW, default 18, number of slide switches handled.
REQ-002 SHALL have parameter TICK_DIV, default 50000, clock cycles per sample tick (1 ms at 50 MHz).
REQ-003 SHALL have parameter STABLE_TICKS, default 10, consecutive mismatching ticks required to accept a new level.
REQ-004 SHALL have port CLOCK_50_I  input  1  system clock; this is the single clock and all state SHALL be clocked on its rising edge.
REQ-005 SHALL have port RESET_I  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port SWITCH_I  input  NUM_SW  raw, asynchronous, bouncing board switches.
REQ-007 SHALL have port SWITCH_DB_O  output  NUM_SW  debounced switch levels, which feed the downstream experiment switch input.
REQ-008 SHALL have port SWITCH_RISE_O  output  NUM_SW  one-cycle pulse per bit on each debounced 0->1 change.
REQ-009 SHALL have port SWITCH_FALL_O  output  NUM_SW  one-cycle pulse per bit on each debounced 1->0 change.
REQ-010 SHALL have port CHANGE_O  output  1  OR of all SWITCH_RISE_O and SWITCH_FALL_O bits in the same cycle.
REQ-011 SHALL have port TICK_O  output  1  one-cycle sample-tick pulse, exposed for verification.

Function
REQ-012 SHALL pass each SWITCH_I bit through a 2-flop synchronizer; sync[i] SHALL be the value of the second flop.
REQ-013 SHALL run a tick counter over 0..TICK_DIV-1 that wraps to 0; TICK_O=1 exactly in the cycles where the count equals TICK_DIV-1.
REQ-014 SHALL keep a per-bit stability counter cnt[i] of width clog2(STABLE_TICKS)+1.
REQ-015 SHALL clear cnt[i] to 0 in any cycle where sync[i]==SWITCH_DB_O[i], regardless of tick.
REQ-016 SHALL increment cnt[i] when sync[i]!=SWITCH_DB_O[i], TICK_O=1 and cnt[i]<STABLE_TICKS-1.
REQ-017 SHALL, when sync[i]!=SWITCH_DB_O[i], TICK_O=1 and cnt[i]==STABLE_TICKS-1, load SWITCH_DB_O[i]<=sync[i] and cnt[i]<=0.
REQ-018 SHALL register SWITCH_RISE_O[i] and SWITCH_FALL_O[i] so that each is high for exactly the first cycle in which SWITCH_DB_O[i] shows the new level.
REQ-019 SHALL never assert SWITCH_RISE_O[i] and SWITCH_FALL_O[i] together; a single bit SHALL produce at most one pulse per STABLE_TICKS*TICK_DIV cycles.
REQ-020 SHALL process bits independently; several bits MAY update and pulse in the same cycle, and CHANGE_O is then a single 1.
REQ-021 SHALL, after a clean SWITCH_I edge at cycle k, update SWITCH_DB_O between cycles k+(STABLE_TICKS-1)*TICK_DIV+3 and k+STABLE_TICKS*TICK_DIV+2 inclusive.
REQ-022 SHALL NOT change SWITCH_DB_O[i] if sync[i] returns to SWITCH_DB_O[i] before the accepting tick; the partial count is discarded.

Reset
REQ-023 SHALL, while RESET_I=1 at a clock edge, clear the synchronizer flops, tick counter, all cnt[i], SWITCH_DB_O, SWITCH_RISE_O, SWITCH_FALL_O, CHANGE_O and TICK_O to 0.
REQ-024 SHALL abandon any debounce in progress when reset is asserted mid-operation; no pulse from before reset SHALL appear afterwards.
REQ-025 SHALL, for a switch held at 1 through reset release, produce one SWITCH_RISE_O pulse after the REQ-021 latency measured from the release cycle.

Verification (TICK_DIV=4, STABLE_TICKS=3)
REQ-026 SHALL check: reset held 5 cycles with SWITCH_I=18'h3FFFF -> all outputs 0 during reset; TICK_O first pulses 4 cycles after release, then every 4 cycles.
REQ-027 SHALL check: SWITCH_I[0] 0->1 cleanly at cycle k -> SWITCH_DB_O[0] rises in [k+11, k+14], with one SWITCH_RISE_O[0] pulse and CHANGE_O=1 in that same cycle.
REQ-028 SHALL check: SWITCH_I[1] toggling every 3 cycles for 40 cycles, then held at 1 -> no pulse while toggling, then exactly one SWITCH_RISE_O[1] pulse.
REQ-029 SHALL check: SWITCH_I[17:16] both 0->1 in the same cycle -> both bits rise in the same cycle, SWITCH_RISE_O=18'h30000 for one cycle, and CHANGE_O high for one cycle.
REQ-030 SHALL check: SWITCH_I[2] 1->0 after it is debounced at 1 -> one SWITCH_FALL_O[2] pulse and no SWITCH_RISE_O activity.
REQ-031 SHALL check: SWITCH_I[3] 0->1, then RESET_I pulsed 1 cycle 6 cycles later -> no pulse before reset; after release, SWITCH_DB_O[3] rises in [11, 14] cycles.
